// File: rtl/keypad_pkg.sv
// Shared types, default timing constants and key-map helpers for the keypad scanner.
// Pure definitions: no latency, no flow control.
package keypad_pkg;

    typedef logic [3:0]  key_code_t;
    typedef logic [15:0] key_map_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        MULTI   = 2'd2
    } kp_state_t;

    localparam int DEF_SCAN_DIV        = 2**14;
    localparam int DEF_DEBOUNCE_FRAMES = 4;
    localparam int DEF_REPEAT_FRAMES   = 64;

    function automatic logic [4:0] key_popcount(input key_map_t m);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) n = n + {4'd0, m[i]};
        return n;
    endfunction

    // Code of the lowest pressed key; only meaningful when exactly one bit is set.
    function automatic key_code_t key_to_code(input key_map_t m);
        key_code_t c;
        c = '0;
        for (int i = 15; i >= 0; i--) if (m[i]) c = i[3:0];
        return c;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
// Latency 2 CLK; no backpressure.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with whole-frame debounce and single-key strobe (auto-repeat with KP_REPEAT_EN).
// KEY_VALID lands 2 CLK after the accepting frame end; free-running, no backpressure.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = DEF_SCAN_DIV,
    parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES,
    parameter int REPEAT_FRAMES   = DEF_REPEAT_FRAMES
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic [3:0] KP_COL,
    input  logic [3:0] KP_ROW,
    output logic       KEY_VALID,
    output key_code_t  KEY_CODE,
    output logic       KEY_HELD,
    output logic       KEY_MULTI
);

    localparam int            CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [3:0]    DEB       = 4'(DEBOUNCE_FRAMES);

    if (SCAN_DIV < 4 || DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15 || REPEAT_FRAMES < 1) begin : g_param_check
        $error("keypad_scanner: parameter out of range");
    end

    logic [CW-1:0] slot_cnt;
    logic [1:0]    col;
    logic [3:0]    row_sync;
    logic          slot_end, frame_end, stable_upd;
    key_map_t      frame, cur_frame, last_frame, stable_map;
    logic [3:0]    stable_cnt, stable_cnt_nxt;

    sync_2ff #(.W(4)) u_row_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .d     (KP_ROW),
        .q     (row_sync)
    );

    assign slot_end  = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_end && (col == 2'd3);
    assign KP_COL    = ~(4'b0001 << col);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            slot_cnt <= '0;
            col      <= '0;
        end else if (slot_end) begin
            slot_cnt <= '0;
            col      <= col + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + CW'(1);
        end
    end

    // Frame as it will stand once the current column's rows are written in.
    always_comb begin
        cur_frame = frame;
        for (int r = 0; r < 4; r++) cur_frame[{2'(r), col}] = ~row_sync[r];
    end

    always_comb begin
        if (cur_frame != last_frame)
            stable_cnt_nxt = 4'd1;
        else if (stable_cnt >= DEB)
            stable_cnt_nxt = DEB;
        else
            stable_cnt_nxt = stable_cnt + 4'd1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            frame      <= '0;
            last_frame <= '0;
            stable_map <= '0;
            stable_cnt <= '0;
            stable_upd <= 1'b0;
        end else begin
            stable_upd <= 1'b0;
            if (slot_end)
                frame <= cur_frame;
            if (frame_end) begin
                stable_cnt <= stable_cnt_nxt;
                last_frame <= cur_frame;
                if (stable_cnt_nxt == DEB) begin
                    stable_map <= cur_frame;
                    stable_upd <= 1'b1;
                end
            end
        end
    end

    kp_state_t  state, state_nxt;
    logic [4:0] key_cnt;
    key_code_t  key_code, code_nxt;
    logic       valid_nxt;

    assign key_cnt  = key_popcount(stable_map);
    assign key_code = key_to_code(stable_map);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (stable_upd) begin
            case (state)
                IDLE:    if (key_cnt == 5'd1)      state_nxt = PRESSED;
                         else if (key_cnt != 5'd0) state_nxt = MULTI;
                PRESSED: if (key_cnt == 5'd0)      state_nxt = IDLE;
                         else if (key_cnt != 5'd1) state_nxt = MULTI;
                MULTI:   if (key_cnt == 5'd0)      state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef KP_REPEAT_EN
    localparam int            RW        = $clog2(REPEAT_FRAMES + 1);
    localparam int            RSTEP     = (REPEAT_FRAMES / 4 < 1) ? 1 : REPEAT_FRAMES / 4;
    localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_FRAMES);
    localparam logic [RW-1:0] RPT_STEP  = RW'(RSTEP);

    logic [RW-1:0] rep_cnt, rep_cnt_nxt;
    logic          rep_phase, rep_phase_nxt;
`endif

    always_comb begin
        valid_nxt = 1'b0;
        code_nxt  = KEY_CODE;
        if (stable_upd && key_cnt == 5'd1 &&
            (state == IDLE || (state == PRESSED && key_code != KEY_CODE))) begin
            valid_nxt = 1'b1;
            code_nxt  = key_code;
        end
`ifdef KP_REPEAT_EN
        rep_cnt_nxt   = rep_cnt;
        rep_phase_nxt = rep_phase;
        if (state_nxt != state || valid_nxt) begin
            rep_cnt_nxt   = '0;
            rep_phase_nxt = 1'b0;
        end else if (stable_upd && state == PRESSED) begin
            // First repeat after the long hold, then at the faster step rate.
            if (rep_cnt + RW'(1) == (rep_phase ? RPT_STEP : RPT_FIRST)) begin
                valid_nxt     = 1'b1;
                rep_cnt_nxt   = '0;
                rep_phase_nxt = 1'b1;
            end else begin
                rep_cnt_nxt = rep_cnt + RW'(1);
            end
        end
`endif
    end

`ifdef KP_REPEAT_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else begin
            rep_cnt   <= rep_cnt_nxt;
            rep_phase <= rep_phase_nxt;
        end
    end
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            KEY_VALID <= 1'b0;
            KEY_CODE  <= '0;
            KEY_HELD  <= 1'b0;
            KEY_MULTI <= 1'b0;
        end else begin
            KEY_VALID <= valid_nxt;
            KEY_CODE  <= code_nxt;
            KEY_HELD  <= (state_nxt == PRESSED);
            KEY_MULTI <= (state_nxt == MULTI);
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a key-matrix model drives KP_ROW; a frame-level reference
// model (run-length debounce plus press/release rules) predicts strobes and flags.
module tb_keypad_scanner;

    localparam int SD    = 4;
    localparam int DEB   = 3;
    localparam int RF    = 8;
    localparam int RSTEP = (RF / 4 < 1) ? 1 : RF / 4;
    localparam int FRAME = 4 * SD;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [3:0]  KP_COL, KP_ROW, KEY_CODE;
    logic        KEY_VALID, KEY_HELD, KEY_MULTI;
    logic [15:0] keys = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] hist[$];
    int          held_key;
    bit          blocked;
    int          rep;
    bit          rep_phase;
    int          exp_n;
    logic [3:0]  exp_code;

    keypad_scanner #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_FRAMES (DEB),
        .REPEAT_FRAMES   (RF)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .KP_COL    (KP_COL),
        .KP_ROW    (KP_ROW),
        .KEY_VALID (KEY_VALID),
        .KEY_CODE  (KEY_CODE),
        .KEY_HELD  (KEY_HELD),
        .KEY_MULTI (KEY_MULTI)
    );

    always #5 CLK = ~CLK;

    // Key (r,c) pressed shorts row r to column c; rows pulled high otherwise.
    always_comb begin
        KP_ROW = 4'hF;
        for (int r = 0; r < 4; r++)
            if ((keys[r*4 +: 4] & ~KP_COL) != 4'h0) KP_ROW[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int one_code(input logic [15:0] m);
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        hist.delete();
        held_key  = -1;
        blocked   = 1'b0;
        rep       = 0;
        rep_phase = 1'b0;
        exp_n     = 0;
        exp_code  = 4'd0;
    endtask

    // A frame is accepted once the last DEB scanned frames are identical.
    task automatic model_frame(input logic [15:0] m);
        bit acc;
        int n;
        hist.push_back(m);
        if (hist.size() > DEB) hist.delete(0);
        acc = (hist.size() == DEB);
        foreach (hist[i]) if (hist[i] != m) acc = 1'b0;
        exp_n = 0;
        if (!acc) return;
        n = $countones(m);
        if (n == 0) begin
            held_key = -1; blocked = 1'b0; rep = 0; rep_phase = 1'b0;
        end else if (n >= 2) begin
            held_key = -1; blocked = 1'b1; rep = 0; rep_phase = 1'b0;
        end else if (!blocked) begin
            if (one_code(m) != held_key) begin
                held_key  = one_code(m);
                exp_n     = 1;
                exp_code  = 4'(held_key);
                rep       = 0;
                rep_phase = 1'b0;
            end
`ifdef KP_REPEAT_EN
            else begin
                rep++;
                if (rep == (rep_phase ? RSTEP : RF)) begin
                    exp_n     = 1;
                    rep       = 0;
                    rep_phase = 1'b1;
                end
            end
`endif
        end
    endtask

    // Entered at the falling edge inside cycle 0 of a scan frame; returns at the next one.
    task automatic run_frame(input bit bounce, input int stop_k, output int nstr, output logic [3:0] scode);
        logic [15:0] smp;
        logic [3:0]  col_exp;
        bit          prev_v, b2b;
        nstr = 0; scode = 4'd0; prev_v = 1'b0; b2b = 1'b0; smp = '0;
        for (int k = 0; k < FRAME; k++) begin
            if (k == stop_k) return;
            if (bounce && (cyc % 5 == 0)) keys[0] = ~keys[0];
            for (int c = 0; c < 4; c++)
                if (k == SD*c + SD - 3)
                    for (int r = 0; r < 4; r++) smp[r*4+c] = keys[r*4+c];
            if (k % SD == 0) begin
                col_exp = ~(4'b0001 << (k / SD));
                check("kp_col", KP_COL, col_exp);
            end
            if (KEY_VALID) begin
                nstr++;
                scode = KEY_CODE;
                if (prev_v) b2b = 1'b1;
            end
            if (k == FRAME / 2) begin
                check("key_held", KEY_HELD, held_key >= 0);
                check("key_multi", KEY_MULTI, blocked);
                check("key_code_held", KEY_CODE, exp_code);
            end
            prev_v = KEY_VALID;
            @(negedge CLK);
            cyc++;
        end
        check("valid_back_to_back", b2b, 1'b0);
        check("strobe_count", nstr, exp_n);
        if (exp_n == 1) check("strobe_code", scode, exp_code);
        model_frame(smp);
    endtask

    task automatic frames(input logic [15:0] m, input int n, output int nsum, output logic [3:0] lastc);
        int         s;
        logic [3:0] c;
        keys = m; nsum = 0; lastc = 4'd0;
        repeat (n) begin
            run_frame(1'b0, FRAME + 1, s, c);
            nsum += s;
            if (s != 0) lastc = c;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        #1;
        check("rst_kp_col", KP_COL, 4'b1110);
        check("rst_valid", KEY_VALID, 1'b0);
        check("rst_code", KEY_CODE, 4'd0);
        check("rst_held", KEY_HELD, 1'b0);
        check("rst_multi", KEY_MULTI, 1'b0);
        repeat (3) @(negedge CLK);
        check("rst_hold_kp_col", KP_COL, 4'b1110);
        RESET = 1'b0;
        model_reset();
    endtask

    initial begin
        int          n, nb, sel, a, b;
        logic [3:0]  c;
        logic [15:0] m;

        do_reset();
        frames(16'h0000, 2, n, c);

        // row2/col1 -> code 9
        frames(16'h0200, 6, n, c);
        check("single_count", n, 1);
        check("single_code", c, 4'd9);
        frames(16'h0000, 5, n, c);
        check("release_count", n, 0);
        check("release_held", KEY_HELD, 1'b0);

        keys = 16'h0000;
        nb = 0;
        repeat (4) begin
            run_frame(1'b1, FRAME + 1, n, c);
            nb += n;
        end
        check("bounce_count", nb, 0);
        frames(16'h0001, 5, n, c);
        check("post_bounce_count", n, 1);
        check("post_bounce_code", c, 4'd0);
        frames(16'h0000, 5, n, c);

        frames(16'h0420, 5, n, c);
        check("multi_count", n, 0);
        check("multi_flag", KEY_MULTI, 1'b1);
        frames(16'h0020, 5, n, c);
        check("multi_partial_count", n, 0);
        check("multi_partial_flag", KEY_MULTI, 1'b1);
        frames(16'h0000, 5, n, c);
        check("multi_release_flag", KEY_MULTI, 1'b0);
        frames(16'h8000, 5, n, c);
        check("after_multi_count", n, 1);
        check("after_multi_code", c, 4'd15);
        frames(16'h0000, 5, n, c);

        // Reset lands in column 2 of the second frame of a press.
        keys = 16'h0040;
        run_frame(1'b0, FRAME + 1, n, c);
        run_frame(1'b0, 2*SD + 1, n, c);
        check("pre_reset_count", n, 0);
        do_reset();
        frames(16'h0040, 5, n, c);
        check("post_reset_count", n, 1);
        check("post_reset_code", c, 4'd6);
        frames(16'h0000, 5, n, c);

`ifdef KP_REPEAT_EN
        frames(16'h0008, 24, n, c);
        check("repeat_count", n, 8);
        check("repeat_code", c, 4'd3);
        frames(16'h0000, 5, n, c);
        check("repeat_stop_count", n, 0);
`endif

        for (int s = 0; s < 25; s++) begin
            sel = $urandom_range(0, 3);
            a   = $urandom_range(0, 15);
            b   = (a + $urandom_range(1, 15)) % 16;
            m   = '0;
            if (sel == 1 || sel == 2) m[a] = 1'b1;
            else if (sel == 3) begin
                m[a] = 1'b1;
                m[b] = 1'b1;
            end
            frames(m, $urandom_range(1, 5), n, c);
        end
        frames(16'h0000, 4, n, c);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
